// File: rtl/apb_to_periph.sv
// APB4 completer to HWPE periph master bridge; one outstanding transfer, rolling ID tag.
// Optional request/response timeout abort enabled by defining APB_TO_PERIPH_TIMEOUT_EN.
module apb_to_periph #(
    parameter int unsigned ID_WIDTH       = 8,
    parameter logic [15:0] CSB_ID         = 16'h0000,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                psel,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [31:0]         paddr,
    input  logic [31:0]         pwdata,
    input  logic [3:0]          pstrb,
    output logic [31:0]         prdata,
    output logic                pready,
    output logic                pslverr,
    output logic                periph_req,
    output logic [31:0]         periph_add,
    output logic                periph_wen,
    output logic [3:0]          periph_be,
    output logic [31:0]         periph_data,
    output logic [ID_WIDTH-1:0] periph_id,
    input  logic                periph_gnt,
    input  logic                periph_r_valid,
    input  logic [31:0]         periph_r_data,
    input  logic [ID_WIDTH-1:0] periph_r_id
);

    typedef enum logic [2:0] {StIdle, StReq, StResp, StDone, StErr} state_e;

    state_e                state_q, state_d;
    logic                  wen_q, wen_d;
    logic [31:0]           add_q, add_d;
    logic [3:0]            be_q, be_d;
    logic [31:0]           data_q, data_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  mism_q, mism_d;
    logic                  timeout;

`ifdef APB_TO_PERIPH_TIMEOUT_EN
    localparam int unsigned CntWidth = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntWidth-1:0] cnt_q;

    // Held at zero in IDLE so it starts fresh on every entry to REQ.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (state_q == StReq || state_q == StResp) begin
            cnt_q <= cnt_q + 1'b1;
        end else begin
            cnt_q <= '0;
        end
    end

    assign timeout = (state_q == StReq || state_q == StResp) &&
                     (cnt_q == CntWidth'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout            = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        wen_d   = wen_q;
        add_d   = add_q;
        be_d    = be_q;
        data_d  = data_q;
        id_d    = id_q;
        rdata_d = rdata_q;
        mism_d  = mism_q;
        unique case (state_q)
            StIdle: begin
                if (psel && !penable) begin
                    wen_d  = ~pwrite;
                    add_d  = paddr;
                    be_d   = pwrite ? pstrb : 4'hF;
                    data_d = pwdata;
                    if (paddr[1:0] != 2'b00 || paddr[31:16] != CSB_ID) begin
                        state_d = StErr;
                    end else begin
                        state_d = StReq;
                    end
                end
            end
            StReq: begin
                if (periph_gnt) begin
                    if (periph_r_valid) begin
                        rdata_d = wen_q ? periph_r_data : 32'h0;
                        mism_d  = (periph_r_id != id_q);
                        state_d = StDone;
                    end else begin
                        state_d = StResp;
                    end
                end else if (timeout) begin
                    id_d    = id_q + 1'b1;
                    state_d = StErr;
                end
            end
            StResp: begin
                if (periph_r_valid) begin
                    rdata_d = wen_q ? periph_r_data : 32'h0;
                    mism_d  = (periph_r_id != id_q);
                    state_d = StDone;
                end else if (timeout) begin
                    id_d    = id_q + 1'b1;
                    state_d = StErr;
                end
            end
            StDone: begin
                id_d    = id_q + 1'b1;
                state_d = StIdle;
            end
            StErr: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            wen_q   <= 1'b0;
            add_q   <= '0;
            be_q    <= '0;
            data_q  <= '0;
            id_q    <= '0;
            rdata_q <= '0;
            mism_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wen_q   <= wen_d;
            add_q   <= add_d;
            be_q    <= be_d;
            data_q  <= data_d;
            id_q    <= id_d;
            rdata_q <= rdata_d;
            mism_q  <= mism_d;
        end
    end

    assign periph_req  = (state_q == StReq);
    assign periph_add  = add_q;
    assign periph_wen  = wen_q;
    assign periph_be   = be_q;
    assign periph_data = data_q;
    assign periph_id   = id_q;

    assign pready  = (state_q == StDone) || (state_q == StErr);
    assign pslverr = (state_q == StErr) || ((state_q == StDone) && mism_q);
    assign prdata  = (state_q == StDone) ? rdata_q : 32'h0;

endmodule

// File: tb/tb_apb_to_periph.sv
// Directed self-checking bench for apb_to_periph; the setup cycle of a transfer counts as cycle 1.
// Define APB_TO_PERIPH_TIMEOUT_EN for both files to also exercise the timeout abort.
module tb_apb_to_periph;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] paddr = '0, pwdata = '0;
    logic [3:0]  pstrb = '0;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic        periph_req, periph_wen;
    logic [31:0] periph_add, periph_data;
    logic [3:0]  periph_be;
    logic [7:0]  periph_id;
    logic        periph_gnt = 1'b0, periph_r_valid = 1'b0;
    logic [31:0] periph_r_data = '0;
    logic [7:0]  periph_r_id = '0;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_id;

    always #5 clk = ~clk;

    apb_to_periph #(
        .ID_WIDTH(8),
        .CSB_ID(16'h0000),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .periph_req(periph_req), .periph_add(periph_add), .periph_wen(periph_wen),
        .periph_be(periph_be), .periph_data(periph_data), .periph_id(periph_id),
        .periph_gnt(periph_gnt), .periph_r_valid(periph_r_valid),
        .periph_r_data(periph_r_data), .periph_r_id(periph_r_id)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        periph_gnt = 1'b0; periph_r_valid = 1'b0;
    endtask

    // Drives the setup cycle, then leaves the bus in the access phase of cycle 2.
    task automatic apb_setup(input logic wr, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
        step();
        penable = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; psel = 1'b1; penable = 1'b0; paddr = 32'h10;
        periph_gnt = 1'b1; periph_r_valid = 1'b1;
        step(); step();
        n_cmp++;
        if ({prdata, pready, pslverr, periph_req, periph_add, periph_wen, periph_be,
             periph_data, periph_id} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got req=%b rdy=%b add=%h id=%h required all zero",
                     periph_req, pready, periph_add, periph_id);
        end
        idle_bus();
        rst_n = 1'b1;
        step();
        n_cmp++;
        if ({pready, periph_req, periph_id} !== '0) begin
            n_err++;
            $display("FAIL reset_idle got rdy=%b req=%b id=%h required 0/0/00",
                     pready, periph_req, periph_id);
        end
    endtask

    task automatic test_write();
        apb_setup(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'h3);
        n_cmp++;
        if ({periph_req, periph_add, periph_wen, periph_be, periph_data, periph_id, pready} !==
            {1'b1, 32'h10, 1'b0, 4'h3, 32'hDEAD_BEEF, 8'h00, 1'b0}) begin
            n_err++;
            $display("FAIL write_req got req=%b add=%h wen=%b be=%h data=%h id=%h rdy=%b required 1/10/0/3/deadbeef/00/0",
                     periph_req, periph_add, periph_wen, periph_be, periph_data, periph_id, pready);
        end
        periph_gnt = 1'b1;
        step();
        periph_gnt = 1'b0;
        n_cmp++;
        if ({periph_req, pready} !== 2'b00) begin
            n_err++;
            $display("FAIL write_resp_wait got req=%b rdy=%b required 0/0", periph_req, pready);
        end
        periph_r_valid = 1'b1; periph_r_id = 8'h00; periph_r_data = 32'hFFFF_FFFF;
        step();
        periph_r_valid = 1'b0;
        n_cmp++;
        if ({pready, pslverr, prdata} !== {1'b1, 1'b0, 32'h0}) begin
            n_err++;
            $display("FAIL write_done_cycle4 got rdy=%b err=%b rdata=%h required 1/0/00000000",
                     pready, pslverr, prdata);
        end
        idle_bus();
        step();
        n_cmp++;
        if ({pready, periph_id} !== {1'b0, 8'h01}) begin
            n_err++;
            $display("FAIL write_next_id got rdy=%b id=%h required 0/01", pready, periph_id);
        end
    endtask

    task automatic test_read_stall();
        int req_cycles;
        req_cycles = 0;
        apb_setup(1'b0, 32'h0000_0020, 32'h0, 4'h0);
        for (int k = 0; k < 6; k++) begin
            if (periph_req) req_cycles++;
            n_cmp++;
            if ({periph_req, periph_add, periph_wen, periph_be, periph_id, pready} !==
                {1'b1, 32'h20, 1'b1, 4'hF, 8'h01, 1'b0}) begin
                n_err++;
                $display("FAIL read_req_stable[%0d] got req=%b add=%h wen=%b be=%h id=%h rdy=%b required 1/20/1/f/01/0",
                         k, periph_req, periph_add, periph_wen, periph_be, periph_id, pready);
            end
            periph_gnt = (k == 5);
            step();
        end
        periph_gnt = 1'b0;
        n_cmp++;
        if ({periph_req, req_cycles} !== {1'b0, 32'd6}) begin
            n_err++;
            $display("FAIL read_req_cycles got req=%b cycles=%0d required 0/6", periph_req, req_cycles);
        end
        periph_r_valid = 1'b1; periph_r_id = 8'h01; periph_r_data = 32'h1234_5678;
        step();
        periph_r_valid = 1'b0;
        n_cmp++;
        if ({pready, pslverr, prdata} !== {1'b1, 1'b0, 32'h1234_5678}) begin
            n_err++;
            $display("FAIL read_done got rdy=%b err=%b rdata=%h required 1/0/12345678",
                     pready, pslverr, prdata);
        end
        idle_bus();
        step();
        n_cmp++;
        if ({pready, pslverr, prdata} !== '0) begin
            n_err++;
            $display("FAIL read_after_done got rdy=%b err=%b rdata=%h required 0/0/00000000",
                     pready, pslverr, prdata);
        end
    endtask

    task automatic test_decode_err();
        logic [31:0] addrs [2];
        addrs[0] = 32'h0000_0022;
        addrs[1] = 32'h0001_0020;
        for (int i = 0; i < 2; i++) begin
            apb_setup(1'b0, addrs[i], 32'h5555_AAAA, 4'hF);
            n_cmp++;
            if ({periph_req, pready, pslverr, prdata} !== {1'b0, 1'b1, 1'b1, 32'h0}) begin
                n_err++;
                $display("FAIL decode_err[%h] got req=%b rdy=%b err=%b rdata=%h required 0/1/1/00000000",
                         addrs[i], periph_req, pready, pslverr, prdata);
            end
            idle_bus();
            step();
            n_cmp++;
            if ({periph_req, pready, periph_id} !== {1'b0, 1'b0, 8'h02}) begin
                n_err++;
                $display("FAIL decode_id[%h] got req=%b rdy=%b id=%h required 0/0/02",
                         addrs[i], periph_req, pready, periph_id);
            end
        end
    endtask

    task automatic test_id_mismatch();
        apb_setup(1'b0, 32'h0000_0030, 32'h0, 4'h0);
        n_cmp++;
        if ({periph_req, periph_id} !== {1'b1, 8'h02}) begin
            n_err++;
            $display("FAIL mism_req got req=%b id=%h required 1/02", periph_req, periph_id);
        end
        periph_gnt = 1'b1; periph_r_valid = 1'b1;
        periph_r_id = 8'h03; periph_r_data = 32'hAAAA_5555;
        step();
        periph_gnt = 1'b0; periph_r_valid = 1'b0;
        n_cmp++;
        if ({pready, pslverr, prdata} !== {1'b1, 1'b1, 32'hAAAA_5555}) begin
            n_err++;
            $display("FAIL mism_done_cycle3 got rdy=%b err=%b rdata=%h required 1/1/aaaa5555",
                     pready, pslverr, prdata);
        end
        idle_bus();
        step();
        n_cmp++;
        if (periph_id !== 8'h03) begin
            n_err++;
            $display("FAIL mism_next_id got %h required 03", periph_id);
        end
    endtask

    task automatic test_id_wrap();
        exp_id = 8'h03;
        for (int n = 0; n < 256; n++) begin
            apb_setup(1'b0, 32'h0000_0100, 32'h0, 4'h0);
            n_cmp++;
            if ({periph_req, periph_id} !== {1'b1, exp_id}) begin
                n_err++;
                $display("FAIL wrap_id[%0d] got req=%b id=%h required 1/%h",
                         n, periph_req, periph_id, exp_id);
            end
            periph_gnt = 1'b1; periph_r_valid = 1'b1;
            periph_r_id = exp_id; periph_r_data = {24'h0, exp_id};
            step();
            n_cmp++;
            if ({pready, pslverr, prdata} !== {1'b1, 1'b0, 24'h0, exp_id}) begin
                n_err++;
                $display("FAIL wrap_done[%0d] got rdy=%b err=%b rdata=%h required 1/0/%h",
                         n, pready, pslverr, prdata, exp_id);
            end
            idle_bus();
            step();
            exp_id = exp_id + 8'd1;
        end
        n_cmp++;
        if (periph_id !== 8'h03) begin
            n_err++;
            $display("FAIL wrap_final_id got %h required 03", periph_id);
        end
    endtask

`ifdef APB_TO_PERIPH_TIMEOUT_EN
    task automatic test_timeout();
        apb_setup(1'b0, 32'h0000_0060, 32'h0, 4'h0);
        for (int k = 0; k < 16; k++) begin
            n_cmp++;
            if ({periph_req, pready} !== 2'b10) begin
                n_err++;
                $display("FAIL timeout_wait[%0d] got req=%b rdy=%b required 1/0", k, periph_req, pready);
            end
            step();
        end
        n_cmp++;
        if ({periph_req, pready, pslverr, prdata} !== {1'b0, 1'b1, 1'b1, 32'h0}) begin
            n_err++;
            $display("FAIL timeout_abort got req=%b rdy=%b err=%b rdata=%h required 0/1/1/00000000",
                     periph_req, pready, pslverr, prdata);
        end
        idle_bus();
        periph_r_valid = 1'b1; periph_r_id = 8'h03;
        step();
        periph_r_valid = 1'b0;
        n_cmp++;
        if ({pready, periph_req, periph_id} !== {1'b0, 1'b0, 8'h04}) begin
            n_err++;
            $display("FAIL timeout_late_resp got rdy=%b req=%b id=%h required 0/0/04",
                     pready, periph_req, periph_id);
        end
    endtask
`endif

    task automatic test_reset_mid();
        apb_setup(1'b0, 32'h0000_0040, 32'h0, 4'h0);
        periph_gnt = 1'b1;
        step();
        idle_bus();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n_cmp++;
        if ({prdata, pready, pslverr, periph_req, periph_add, periph_wen, periph_be,
             periph_data, periph_id} !== '0) begin
            n_err++;
            $display("FAIL midreset_outputs got rdy=%b req=%b add=%h id=%h required all zero",
                     pready, periph_req, periph_add, periph_id);
        end
        periph_r_valid = 1'b1; periph_r_id = 8'h03; periph_r_data = 32'hFFFF_0000;
        periph_gnt = 1'b1;
        step();
        step();
        periph_r_valid = 1'b0; periph_gnt = 1'b0;
        n_cmp++;
        if ({pready, pslverr, prdata, periph_req, periph_id} !== '0) begin
            n_err++;
            $display("FAIL midreset_stray got rdy=%b err=%b rdata=%h req=%b id=%h required all zero",
                     pready, pslverr, prdata, periph_req, periph_id);
        end
        apb_setup(1'b1, 32'h0000_0050, 32'hCAFE_F00D, 4'hF);
        n_cmp++;
        if ({periph_req, periph_add, periph_wen, periph_data, periph_id} !==
            {1'b1, 32'h50, 1'b0, 32'hCAFE_F00D, 8'h00}) begin
            n_err++;
            $display("FAIL midreset_next_req got req=%b add=%h wen=%b data=%h id=%h required 1/50/0/cafef00d/00",
                     periph_req, periph_add, periph_wen, periph_data, periph_id);
        end
        periph_gnt = 1'b1; periph_r_valid = 1'b1; periph_r_id = 8'h00;
        step();
        n_cmp++;
        if ({pready, pslverr, prdata} !== {1'b1, 1'b0, 32'h0}) begin
            n_err++;
            $display("FAIL midreset_next_done got rdy=%b err=%b rdata=%h required 1/0/00000000",
                     pready, pslverr, prdata);
        end
        idle_bus();
        step();
        n_cmp++;
        if (periph_id !== 8'h01) begin
            n_err++;
            $display("FAIL midreset_next_id got %h required 01", periph_id);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_write();
        test_read_stall();
        test_decode_err();
        test_id_mismatch();
        test_id_wrap();
`ifdef APB_TO_PERIPH_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
